// File: rtl/pong_pkg.sv
// Shared geometry, limits and encodings for the pong game-state stage.
// Imported by pong_paddle and pong_game_logic.
package pong_pkg;

  localparam int WIDTH         = 640;
  localparam int HEIGHT        = 480;
  localparam int PADDLE_WIDTH  = 20;
  localparam int PADDLE_HEIGHT = 80;
  localparam int BALL_SIZE     = 20;
  localparam int PADDLE_SPEED  = 4;
  localparam int BALL_SPEED    = 3;

  localparam int PADDLE_Y_MAX = HEIGHT - PADDLE_HEIGHT;
  localparam int PADDLE_Y0    = (HEIGHT - PADDLE_HEIGHT) / 2;
  localparam int BALL_Y_MAX   = HEIGHT - BALL_SIZE;
  localparam int BALL_X_MIN   = PADDLE_WIDTH;
  localparam int BALL_X_MAX   = WIDTH - PADDLE_WIDTH - BALL_SIZE;
  localparam int CENTER_X     = (WIDTH - BALL_SIZE) / 2;
  localparam int CENTER_Y     = (HEIGHT - BALL_SIZE) / 2;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } game_state_t;

  // POS = right on x, down on y
  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_t;

  // one guard bit so compares never wrap
  typedef logic [10:0] coord_t;

endpackage

// File: rtl/pong_paddle.sv
// Saturating paddle position register (top row), 0..PADDLE_Y_MAX.
// Ports: clk, reset, en (frame update), up, down, y (paddle top row).
module pong_paddle
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       down,
  output logic [9:0] y
);

  coord_t     y_w;
  logic [9:0] y_nxt;

  always_comb begin
    y_w   = {1'b0, y};
    y_nxt = y;
    unique case (1'b1)
      (up && !down): begin
        if (y_w < 11'(PADDLE_SPEED))
          y_nxt = '0;
        else
          y_nxt = 10'(y_w - 11'(PADDLE_SPEED));
      end
      (down && !up): begin
        if (y_w + 11'(PADDLE_SPEED) >= 11'(PADDLE_Y_MAX))
          y_nxt = 10'(PADDLE_Y_MAX);
        else
          y_nxt = 10'(y_w + 11'(PADDLE_SPEED));
      end
      default: y_nxt = y;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      y <= 10'(PADDLE_Y0);
    else if (en)
      y <= y_nxt;
  end

endmodule

// File: rtl/pong_game_logic.sv
// Pong game state: paddles, ball, scores and serve/play/game-over FSM,
// advanced once per frame_tick. Outputs registered, 1 clk after tick.
module pong_game_logic
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  input  logic       start,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] game_state
);

  localparam int CW = (SERVE_FRAMES > 1) ?
                      $clog2(SERVE_FRAMES) : 1;

  game_state_t   state_q, state_d;
  logic [9:0]    bx_q, bx_d;
  logic [9:0]    by_q, by_d;
  dir_t          dx_q, dx_d;
  dir_t          dy_q, dy_d;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       pad_en;
  coord_t     x_w, y_w, p1_w, p2_w;
  logic [9:0] nx, ny;
  dir_t       ndx, ndy;
  logic       hit1, hit2;
  logic       miss1, miss2;
  logic [3:0] s1_inc, s2_inc;

  assign pad_en = frame_tick && (state_q != GAME_OVER);

  pong_paddle u_pad1 (
    .clk   (clk),
    .reset (reset),
    .en    (pad_en),
    .up    (p1_up),
    .down  (p1_down),
    .y     (paddle1_y)
  );

  pong_paddle u_pad2 (
    .clk   (clk),
    .reset (reset),
    .en    (pad_en),
    .up    (p2_up),
    .down  (p2_down),
    .y     (paddle2_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SERVE;
      bx_q    <= 10'(CENTER_X);
      by_q    <= 10'(CENTER_Y);
      dx_q    <= DIR_POS;
      dy_q    <= DIR_POS;
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    cnt_d   = cnt_q;

    x_w    = {1'b0, bx_q};
    y_w    = {1'b0, by_q};
    p1_w   = {1'b0, paddle1_y};
    p2_w   = {1'b0, paddle2_y};
    s1_inc = s1_q + 4'd1;
    s2_inc = s2_q + 4'd1;

    // paddles as they were before this tick
    hit1 = (y_w + 11'(BALL_SIZE) > p1_w) &&
           (y_w < p1_w + 11'(PADDLE_HEIGHT));
    hit2 = (y_w + 11'(BALL_SIZE) > p2_w) &&
           (y_w < p2_w + 11'(PADDLE_HEIGHT));

    ny  = by_q;
    ndy = dy_q;
    if (dy_q == DIR_POS) begin
      if (y_w + 11'(BALL_SPEED) >= 11'(BALL_Y_MAX)) begin
        ny  = 10'(BALL_Y_MAX);
        ndy = DIR_NEG;
      end else begin
        ny = 10'(y_w + 11'(BALL_SPEED));
      end
    end else begin
      if (y_w < 11'(BALL_SPEED)) begin
        ny  = '0;
        ndy = DIR_POS;
      end else begin
        ny = 10'(y_w - 11'(BALL_SPEED));
      end
    end

    nx    = bx_q;
    ndx   = dx_q;
    miss1 = 1'b0;
    miss2 = 1'b0;
    if (dx_q == DIR_NEG &&
        x_w <= 11'(BALL_X_MIN + BALL_SPEED)) begin
      if (hit1) begin
        nx  = 10'(BALL_X_MIN);
        ndx = DIR_POS;
      end else begin
        miss1 = 1'b1;
      end
    end else if (dx_q == DIR_POS &&
                 x_w + 11'(BALL_SPEED) >= 11'(BALL_X_MAX)) begin
      if (hit2) begin
        nx  = 10'(BALL_X_MAX);
        ndx = DIR_NEG;
      end else begin
        miss2 = 1'b1;
      end
    end else if (dx_q == DIR_POS) begin
      nx = 10'(x_w + 11'(BALL_SPEED));
    end else begin
      nx = 10'(x_w - 11'(BALL_SPEED));
    end

    unique case (state_q)
      SERVE: begin
        if (frame_tick) begin
          if (cnt_q == CW'(SERVE_FRAMES - 1)) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      PLAY: begin
        if (frame_tick) begin
          unique case (1'b1)
            miss1: begin
              s2_d = s2_inc;
              if (s2_inc == 4'(WIN_SCORE)) begin
                state_d = GAME_OVER;
              end else begin
                bx_d    = 10'(CENTER_X);
                by_d    = 10'(CENTER_Y);
                dx_d    = DIR_NEG;
                cnt_d   = '0;
                state_d = SERVE;
              end
            end
            miss2: begin
              s1_d = s1_inc;
              if (s1_inc == 4'(WIN_SCORE)) begin
                state_d = GAME_OVER;
              end else begin
                bx_d    = 10'(CENTER_X);
                by_d    = 10'(CENTER_Y);
                dx_d    = DIR_POS;
                cnt_d   = '0;
                state_d = SERVE;
              end
            end
            default: begin
              bx_d = nx;
              by_d = ny;
              dx_d = ndx;
              dy_d = ndy;
            end
          endcase
        end
      end
      GAME_OVER: begin
        if (start) begin
          bx_d    = 10'(CENTER_X);
          by_d    = 10'(CENTER_Y);
          dx_d    = DIR_POS;
          dy_d    = DIR_POS;
          s1_d    = '0;
          s2_d    = '0;
          cnt_d   = '0;
          state_d = SERVE;
        end
      end
      default: state_d = SERVE;
    endcase
  end

  always_comb begin
    ball_x     = bx_q;
    ball_y     = by_q;
    score1     = s1_q;
    score2     = s2_q;
    game_state = state_q;
  end

endmodule

// File: tb/tb_pong_game_logic.sv
// Testbench for pong_game_logic: directed scenarios plus random play
// compared each cycle against a behavioural game model.
module tb_pong_game_logic;

  localparam int SF = 60;
  localparam int WS = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       p1_up = 1'b0;
  logic       p1_down = 1'b0;
  logic       p2_up = 1'b0;
  logic       p2_down = 1'b0;
  logic       start = 1'b0;
  logic [9:0] paddle1_y, paddle2_y;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score1, score2;
  logic [1:0] game_state;

  always #5 clk = ~clk;

  pong_game_logic dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p2_up      (p2_up),
    .p2_down    (p2_down),
    .start      (start),
    .paddle1_y  (paddle1_y),
    .paddle2_y  (paddle2_y),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .score1     (score1),
    .score2     (score2),
    .game_state (game_state)
  );

  int n_chk = 0;
  int n_err = 0;

  // model: 0 serve, 1 play, 2 game over; dirs are +1/-1
  int m_p1, m_p2, m_bx, m_by, m_dx, m_dy;
  int m_s1, m_s2, m_frames, m_st;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input int exp);
    n_chk++;
    if (obs !== 16'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  function automatic int pad_move(int y, bit up, bit dn);
    if (up && !dn) return (y - 4 > 0) ? y - 4 : 0;
    if (dn && !up) return (y + 4 < 400) ? y + 4 : 400;
    return y;
  endfunction

  function automatic bit covers(int by, int py);
    return (by + 20 > py) && (by < py + 80);
  endfunction

  task automatic m_reset(input bit keep_pads);
    if (!keep_pads) begin
      m_p1 = 200;
      m_p2 = 200;
    end
    m_bx = 310;
    m_by = 230;
    m_dx = 1;
    m_dy = 1;
    m_s1 = 0;
    m_s2 = 0;
    m_frames = 0;
    m_st = 0;
  endtask

  task automatic m_step(input bit rst, input bit tk,
                        input bit u1, input bit d1,
                        input bit u2, input bit d2,
                        input bit st);
    int np1, np2, nx, ny, ndx, ndy, loser;
    if (rst) begin
      m_reset(1'b0);
      return;
    end
    if (m_st == 2) begin
      if (st) m_reset(1'b1);
      return;
    end
    if (!tk) return;
    np1 = pad_move(m_p1, u1, d1);
    np2 = pad_move(m_p2, u2, d2);
    if (m_st == 0) begin
      m_frames++;
      if (m_frames == SF) begin
        m_frames = 0;
        m_st = 1;
      end
    end else begin
      ny = m_by + 3 * m_dy;
      ndy = m_dy;
      if (m_dy > 0 && ny >= 460) begin
        ny = 460;
        ndy = -1;
      end
      if (m_dy < 0 && ny < 0) begin
        ny = 0;
        ndy = 1;
      end
      nx = m_bx + 3 * m_dx;
      ndx = m_dx;
      loser = 0;
      if (m_dx < 0 && m_bx <= 23) begin
        if (covers(m_by, m_p1)) begin
          nx = 20;
          ndx = 1;
        end else loser = 1;
      end else if (m_dx > 0 && m_bx + 3 >= 600) begin
        if (covers(m_by, m_p2)) begin
          nx = 600;
          ndx = -1;
        end else loser = 2;
      end
      if (loser != 0) begin
        if (loser == 1) m_s2++;
        else m_s1++;
        if (m_s1 == WS || m_s2 == WS) begin
          m_st = 2;
        end else begin
          m_bx = 310;
          m_by = 230;
          m_dx = (loser == 1) ? -1 : 1;
          m_frames = 0;
          m_st = 0;
        end
      end else begin
        m_bx = nx;
        m_by = ny;
        m_dx = ndx;
        m_dy = ndy;
      end
    end
    m_p1 = np1;
    m_p2 = np2;
  endtask

  task automatic check_all();
    chk("paddle1_y", paddle1_y, m_p1);
    chk("paddle2_y", paddle2_y, m_p2);
    chk("ball_x", ball_x, m_bx);
    chk("ball_y", ball_y, m_by);
    chk("score1", score1, m_s1);
    chk("score2", score2, m_s2);
    chk("game_state", game_state, m_st);
  endtask

  task automatic step(input bit rst, input bit tk,
                      input bit u1, input bit d1,
                      input bit u2, input bit d2,
                      input bit st);
    reset = rst;
    frame_tick = tk;
    p1_up = u1;
    p1_down = d1;
    p2_up = u2;
    p2_down = d2;
    start = st;
    m_step(rst, tk, u1, d1, u2, d2, st);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n,
                       input bit u1, input bit d1,
                       input bit u2, input bit d2);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1, u1, d1, u2, d2, 1'b0);
  endtask

  function automatic bit trk_up(int py);
    return (py + 40) > (m_by + 12);
  endfunction

  function automatic bit trk_dn(int py);
    return (py + 40) < (m_by + 8);
  endfunction

  int sv_p1, sv_p2, sv_bx, sv_by;
  int lim;
  bit t1, t2, u1, d1, u2, d2, tk, rs, st;

  initial begin
    m_reset(1'b0);
    step(1'b1, 1'b0, 0, 0, 0, 0, 0);
    chk("rst_p1", paddle1_y, 200);
    chk("rst_p2", paddle2_y, 200);
    chk("rst_bx", ball_x, 310);
    chk("rst_by", ball_y, 230);
    chk("rst_s1", score1, 0);
    chk("rst_s2", score2, 0);
    chk("rst_state", game_state, 0);

    ticks(59, 0, 0, 0, 0);
    chk("serve59_state", game_state, 0);
    chk("serve59_bx", ball_x, 310);
    chk("serve59_by", ball_y, 230);
    ticks(1, 0, 0, 0, 0);
    chk("tick60_state", game_state, 1);
    chk("tick60_bx", ball_x, 310);
    ticks(1, 0, 0, 0, 0);
    chk("tick61_bx", ball_x, 313);
    chk("tick61_by", ball_y, 233);
    ticks(75, 0, 0, 0, 0);
    chk("y458", ball_y, 458);
    ticks(1, 0, 0, 0, 0);
    chk("y460", ball_y, 460);
    ticks(1, 0, 0, 0, 0);
    chk("y457", ball_y, 457);
    ticks(1, 0, 0, 0, 0);
    chk("y454", ball_y, 454);
    ticks(18, 0, 0, 0, 0);
    chk("rmiss_s1", score1, 1);
    chk("rmiss_state", game_state, 0);
    chk("rmiss_bx", ball_x, 310);
    chk("rmiss_by", ball_y, 230);

    // paddle saturation and both-pressed hold
    step(1'b1, 1'b0, 0, 0, 0, 0, 0);
    ticks(60, 1, 0, 0, 0);
    chk("p1_sat0", paddle1_y, 0);
    ticks(10, 0, 1, 0, 0);
    chk("p1_dn40", paddle1_y, 40);
    ticks(5, 1, 1, 0, 0);
    chk("p1_both", paddle1_y, 40);

    // right paddle hit, then a tracked rally
    step(1'b1, 1'b0, 0, 0, 0, 0, 0);
    ticks(60, 0, 0, 0, 1);
    chk("p2_sat400", paddle2_y, 400);
    ticks(97, 0, 0, 0, 0);
    chk("rhit_bx", ball_x, 600);
    chk("rhit_state", game_state, 1);
    chk("rhit_s1", score1, 0);
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b1, trk_up(m_p1), trk_dn(m_p1),
           0, 0, 1'b0);

    // reset between ticks during play
    lim = 0;
    while (m_st != 1 && lim < 200) begin
      ticks(1, 0, 0, 0, 0);
      lim++;
    end
    chk("pre_rst_play", game_state, 1);
    step(1'b0, 1'b0, 0, 0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0, 0, 0);
    chk("mid_rst_bx", ball_x, 310);
    chk("mid_rst_by", ball_y, 230);
    chk("mid_rst_p1", paddle1_y, 200);
    chk("mid_rst_state", game_state, 0);

    // play to game over, freeze, start with tick
    lim = 0;
    while (m_st != 2 && lim < 20000) begin
      step(1'b0, 1'b1, trk_up(m_p1), trk_dn(m_p1),
           1'b0, 1'b1, 1'b0);
      lim++;
    end
    chk("reach_go", game_state, 2);
    chk("go_score", (score1 == 4'(WS) || score2 == 4'(WS)),
        1);
    sv_p1 = m_p1;
    sv_p2 = m_p2;
    sv_bx = m_bx;
    sv_by = m_by;
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 1'b0);
    chk("go_frz_bx", ball_x, sv_bx);
    chk("go_frz_by", ball_y, sv_by);
    chk("go_frz_p1", paddle1_y, sv_p1);
    step(1'b0, 1'b1, 1, 0, 0, 1, 1'b1);
    chk("start_s1", score1, 0);
    chk("start_s2", score2, 0);
    chk("start_state", game_state, 0);
    chk("start_p1", paddle1_y, sv_p1);
    chk("start_p2", paddle2_y, sv_p2);
    chk("start_bx", ball_x, 310);

    // random play against the model
    t1 = 1'b1;
    t2 = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      if (c % 256 == 0) begin
        t1 = ($urandom_range(0, 3) != 0);
        t2 = ($urandom_range(0, 3) != 0);
      end
      if (t1 && $urandom_range(0, 7) != 0) begin
        u1 = trk_up(m_p1);
        d1 = trk_dn(m_p1);
      end else begin
        u1 = 1'($urandom);
        d1 = 1'($urandom);
      end
      if (t2 && $urandom_range(0, 7) != 0) begin
        u2 = trk_up(m_p2);
        d2 = trk_dn(m_p2);
      end else begin
        u2 = 1'($urandom);
        d2 = 1'($urandom);
      end
      tk = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 4999) == 0);
      if (m_st == 2)
        st = ($urandom_range(0, 19) == 0);
      else
        st = ($urandom_range(0, 199) == 0);
      step(rs, tk, u1, d1, u2, d2, st);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
